id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Parametrised ID/EX pipeline slot for the OpenMIPS core: carries decoded operation, operands, destination and delay-slot information from decode to execute. It replaces the free-running ID/EX register with a valid/ready handshake, an optional two-entry skid buffer, flush support for exceptions and branches, and a saturating EX-idle counter for performance measurement. It sits between `id` and `ex`; `ctrl` drives `flush`.

## Interface
- `REG_W`, 32: operand / link-address width
- `ADDR_W`, 5: register-file address width
- `ALUOP_W`, 8: aluop width
- `ALUSEL_W`, 3: alusel width
- `SKID`, 1: 1 = two-entry skid buffer with registered `id_ready`; 0 = single entry with combinational `id_ready`
- `CNT_W`, 16: idle-counter width

- `clk` in 1: single clock; all state changes on its rising edge
- `rst` in 1: synchronous, active-low reset
- `flush` in 1: discard every held entry
- `id_valid` in 1: ID presents an instruction
- `id_ready` out 1: slot accepts this cycle
- `id_alusel` in ALUSEL_W, `id_aluop` in ALUOP_W: operation class / code
- `id_reg1`, `id_reg2` in REG_W: source operands
- `id_wd` in ADDR_W, `id_wreg` in 1: destination register, write enable
- `id_link_addr` in REG_W: return address for link instructions
- `id_is_in_delayslot` in 1: current instruction sits in a delay slot
- `id_next_inst_in_delayslot` in 1: next instruction will sit in a delay slot
- `ex_valid` out 1, `ex_ready` in 1: EX-side handshake
- `ex_alusel`, `ex_aluop`, `ex_reg1`, `ex_reg2`, `ex_wd`, `ex_wreg`, `ex_link_addr`, `ex_is_in_delayslot` out: registered copies of the ID fields
- `is_in_delayslot_o` out 1: delay-slot flag returned to ID
- `idle_cnt` out CNT_W: cycles in which EX was ready but the slot was empty

## Operation
- Accept when `id_valid && id_ready`. Hand off when `ex_valid && ex_ready`.
- Entries: main (drives `ex_*`) and skid (present only when SKID=1).
- SKID=1:
  - `id_ready` = !skid_full, registered.
  - Accept with main empty, or main handing off: payload goes to main.
  - Accept with main full and not handing off: payload goes to skid, skid_full=1.
  - Hand off with skid full: skid moves to main, skid_full=0. A simultaneous accept is impossible because `id_ready`=0.
- SKID=0: `id_ready` = !ex_valid || ex_ready, combinational. No skid state.
- Empty slot (`ex_valid`=0): every `ex_*` payload output is forced to NOP (all zero, `ex_wreg`=0). EX never sees stale payload.
- `is_in_delayslot_o` is loaded with `id_next_inst_in_delayslot` on each accept and holds otherwise.
- `flush`:
  - Clears main, skid, `ex_valid` and `is_in_delayslot_o`.
  - Outputs go to NOP and `id_ready` returns to 1 the next cycle.
  - Flush overrides any same-cycle accept or hand-off; the accepted instruction is dropped.
- `idle_cnt` increments in each cycle with `ex_ready && !ex_valid`, and saturates at all ones. `flush` does not clear it.
- Reset (`rst`=0, checked at the edge): `ex_valid`=0, all `ex_*`=0, `is_in_delayslot_o`=0, skid empty, `idle_cnt`=0. `id_ready`=1 in the cycle after reset, for both SKID values. Reset overrides flush and all transfers.

## Timing
- Latency: accept at edge N gives `ex_valid`=1 with payload from N+1.
- Throughput: one instruction per cycle while `ex_ready`=1.
- Backpressure (SKID=1): the first stalled accept lands in skid. `id_ready` drops in the cycle after skid fills. `id_ready` rises in the cycle after the skid drains.
- Order is preserved: main always holds the older entry, skid the younger.
- `ex_*` is stable while `ex_valid && !ex_ready`.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `id_valid`=1 and `id_aluop`=8'h21 -> `ex_valid`=0 and all outputs 0. After release, `id_ready`=1.
- Streaming: `ex_ready`=1, five back-to-back instructions with `id_reg1`=1..5 -> `ex_reg1`=1..5 on consecutive cycles, one cycle after each accept. `idle_cnt` does not move while `ex_valid`=1.
- Backpressure, SKID=1: hold `ex_ready`=0 and send A then B -> `ex_*`=A held. B sits in skid and `id_ready`=0. Release `ex_ready` -> A, then B, with no loss or duplication.
- Flush with skid full, plus a same-cycle accept -> next cycle `ex_valid`=0, `ex_wreg`=0, `id_ready`=1, `is_in_delayslot_o`=0. The accepted instruction never appears.
- Delay slot: accept a branch with `id_next_inst_in_delayslot`=1 -> `is_in_delayslot_o`=1. The following accept with `id_is_in_delayslot`=1 gives `ex_is_in_delayslot`=1.
- Idle saturation: CNT_W=4, `ex_ready`=1, no input for 20 cycles -> `idle_cnt`=15, held. SKID=0: `id_ready` follows `ex_ready` in the same cycle while full.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline slot: valid/ready handshake between decode and execute,
// optional two-entry skid buffer, flush, and a saturating EX-idle counter.
module id_ex_stage #(
  parameter int REG_W    = 32,
  parameter int ADDR_W   = 5,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3,
  parameter int SKID     = 1,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic [ALUSEL_W-1:0] id_alusel,
  input  logic [ALUOP_W-1:0]  id_aluop,
  input  logic [REG_W-1:0]    id_reg1,
  input  logic [REG_W-1:0]    id_reg2,
  input  logic [ADDR_W-1:0]   id_wd,
  input  logic                id_wreg,
  input  logic [REG_W-1:0]    id_link_addr,
  input  logic                id_is_in_delayslot,
  input  logic                id_next_inst_in_delayslot,
  output logic                ex_valid,
  input  logic                ex_ready,
  output logic [ALUSEL_W-1:0] ex_alusel,
  output logic [ALUOP_W-1:0]  ex_aluop,
  output logic [REG_W-1:0]    ex_reg1,
  output logic [REG_W-1:0]    ex_reg2,
  output logic [ADDR_W-1:0]   ex_wd,
  output logic                ex_wreg,
  output logic [REG_W-1:0]    ex_link_addr,
  output logic                ex_is_in_delayslot,
  output logic                is_in_delayslot_o,
  output logic [CNT_W-1:0]    idle_cnt
);

  localparam int PW = ALUSEL_W + ALUOP_W + 3 * REG_W + ADDR_W + 2;

  logic [PW-1:0]    id_pl;
  logic [PW-1:0]    main_q;
  logic             valid_q;
  logic             dly_q;
  logic             accept;
  logic             handoff;
  logic [CNT_W-1:0] idle_q;

  assign id_pl   = {id_alusel, id_aluop, id_reg1, id_reg2, id_wd, id_wreg,
                    id_link_addr, id_is_in_delayslot};
  assign accept  = id_valid && id_ready;
  assign handoff = valid_q && ex_ready;

  if (SKID != 0) begin : g_skid
    logic [PW-1:0] skid_q;
    logic          skid_full;

    // Ready comes straight from a flop, so ID never sees a combinational path from EX
    assign id_ready = !skid_full;

    // Main holds the older entry; skid catches the one accepted while main is stalled
    always_ff @(posedge clk) begin
      if (!rst || flush) begin
        valid_q   <= 1'b0;
        main_q    <= '0;
        skid_q    <= '0;
        skid_full <= 1'b0;
      end else if (handoff && skid_full) begin
        main_q    <= skid_q;
        skid_full <= 1'b0;
      end else if (accept && (!valid_q || handoff)) begin
        main_q  <= id_pl;
        valid_q <= 1'b1;
      end else if (accept) begin
        skid_q    <= id_pl;
        skid_full <= 1'b1;
      end else if (handoff) begin
        valid_q <= 1'b0;
      end
    end
  end else begin : g_direct
    assign id_ready = !valid_q || ex_ready;

    // Single entry: load on accept, empty on a hand-off with nothing behind it
    always_ff @(posedge clk) begin
      if (!rst || flush) begin
        valid_q <= 1'b0;
        main_q  <= '0;
      end else if (accept) begin
        main_q  <= id_pl;
        valid_q <= 1'b1;
      end else if (handoff) begin
        valid_q <= 1'b0;
      end
    end
  end

  // Delay-slot flag returned to ID tracks the most recent accepted instruction
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      dly_q <= 1'b0;
    end else if (accept) begin
      dly_q <= id_next_inst_in_delayslot;
    end
  end

  // Count cycles where EX could take work but the slot is empty; flush leaves it alone
  always_ff @(posedge clk) begin
    if (!rst) begin
      idle_q <= '0;
    end else if (ex_ready && !valid_q && idle_q != '1) begin
      idle_q <= idle_q + CNT_W'(1);
    end
  end

  // An empty slot presents a NOP so EX never acts on stale payload
  always_comb begin
    ex_valid = valid_q;
    {ex_alusel, ex_aluop, ex_reg1, ex_reg2, ex_wd, ex_wreg, ex_link_addr,
     ex_is_in_delayslot} = valid_q ? main_q : '0;
  end

  assign is_in_delayslot_o = dly_q;
  assign idle_cnt          = idle_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: one skid instance and one single-entry instance,
// both checked every cycle against a FIFO-of-instructions reference model.
module tb_id_ex_stage;

  localparam int PW = 114;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        id_valid = 1'b0;
  logic        ex_ready = 1'b0;
  logic [2:0]  alusel = '0;
  logic [7:0]  aluop = '0;
  logic [31:0] reg1 = '0;
  logic [31:0] reg2 = '0;
  logic [4:0]  wd = '0;
  logic        wreg = 1'b0;
  logic [31:0] link = '0;
  logic        isd = 1'b0;
  logic        nxt = 1'b0;

  logic        rdy [2];
  logic        vld [2];
  logic        dly [2];
  logic [3:0]  idle [2];
  logic [2:0]  o_alusel [2];
  logic [7:0]  o_aluop [2];
  logic [31:0] o_reg1 [2];
  logic [31:0] o_reg2 [2];
  logic [4:0]  o_wd [2];
  logic        o_wreg [2];
  logic [31:0] o_link [2];
  logic        o_isd [2];

  int checks = 0;
  int errors = 0;

  // Reference model: per instance, an ordered list of in-flight instructions
  logic [PW-1:0] mfifo [2][2];
  int unsigned   mcnt [2] = '{0, 0};
  logic          mdly [2] = '{1'b0, 1'b0};
  int unsigned   midle [2] = '{0, 0};

  always #5 clk = ~clk;

  id_ex_stage #(.SKID(0), .CNT_W(4)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(rdy[0]),
    .id_alusel(alusel), .id_aluop(aluop), .id_reg1(reg1), .id_reg2(reg2),
    .id_wd(wd), .id_wreg(wreg), .id_link_addr(link), .id_is_in_delayslot(isd),
    .id_next_inst_in_delayslot(nxt), .ex_valid(vld[0]), .ex_ready(ex_ready),
    .ex_alusel(o_alusel[0]), .ex_aluop(o_aluop[0]), .ex_reg1(o_reg1[0]),
    .ex_reg2(o_reg2[0]), .ex_wd(o_wd[0]), .ex_wreg(o_wreg[0]),
    .ex_link_addr(o_link[0]), .ex_is_in_delayslot(o_isd[0]),
    .is_in_delayslot_o(dly[0]), .idle_cnt(idle[0]));

  id_ex_stage #(.SKID(1), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(rdy[1]),
    .id_alusel(alusel), .id_aluop(aluop), .id_reg1(reg1), .id_reg2(reg2),
    .id_wd(wd), .id_wreg(wreg), .id_link_addr(link), .id_is_in_delayslot(isd),
    .id_next_inst_in_delayslot(nxt), .ex_valid(vld[1]), .ex_ready(ex_ready),
    .ex_alusel(o_alusel[1]), .ex_aluop(o_aluop[1]), .ex_reg1(o_reg1[1]),
    .ex_reg2(o_reg2[1]), .ex_wd(o_wd[1]), .ex_wreg(o_wreg[1]),
    .ex_link_addr(o_link[1]), .ex_is_in_delayslot(o_isd[1]),
    .is_in_delayslot_o(dly[1]), .idle_cnt(idle[1]));

  task automatic chk(input string tag, input int k, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[u%0d]: got %h expected %h", tag, k, obs, exp);
    end
  endtask

  function automatic logic model_ready(input int k);
    if (k == 1) return mcnt[1] < 2;
    return mcnt[0] == 0 || ex_ready;
  endfunction

  task automatic check_all();
    logic [PW-1:0] exp_pl;
    logic [PW-1:0] obs_pl;
    for (int k = 0; k < 2; k++) begin
      exp_pl = (mcnt[k] > 0) ? mfifo[k][0] : '0;
      obs_pl = {o_alusel[k], o_aluop[k], o_reg1[k], o_reg2[k], o_wd[k],
                o_wreg[k], o_link[k], o_isd[k]};
      chk("ex_valid", k, 128'(vld[k]), 128'(mcnt[k] > 0));
      chk("id_ready", k, 128'(rdy[k]), 128'(model_ready(k)));
      chk("ex_payload", k, 128'(obs_pl), 128'(exp_pl));
      chk("dly_out", k, 128'(dly[k]), 128'(mdly[k]));
      chk("idle_cnt", k, 128'(idle[k]), 128'(midle[k]));
    end
  endtask

  task automatic model_edge();
    logic [PW-1:0] pl;
    logic r;
    logic h;
    pl = {alusel, aluop, reg1, reg2, wd, wreg, link, isd};
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        mcnt[k] = 0; mdly[k] = 1'b0; midle[k] = 0;
      end else begin
        if (ex_ready && mcnt[k] == 0 && midle[k] < 15) midle[k]++;
        if (flush) begin
          mcnt[k] = 0; mdly[k] = 1'b0;
        end else begin
          r = model_ready(k);
          h = mcnt[k] > 0 && ex_ready;
          if (h) begin
            mfifo[k][0] = mfifo[k][1];
            mcnt[k]--;
          end
          if (id_valid && r) begin
            mfifo[k][mcnt[k]] = pl;
            mcnt[k]++;
            mdly[k] = nxt;
          end
        end
      end
    end
  endtask

  // Inputs change just after a rising edge; outputs are checked on the falling edge
  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rand_fields();
    alusel = 3'($urandom); aluop = 8'($urandom); reg1 = $urandom; reg2 = $urandom;
    wd = 5'($urandom); wreg = 1'($urandom); link = $urandom;
    isd = 1'($urandom); nxt = 1'($urandom);
  endtask

  initial begin
    // Reset held two checked cycles with a pending instruction
    rst = 1'b0; id_valid = 1'b1; aluop = 8'h21; ex_ready = 1'b1;
    @(posedge clk); model_edge(); #1;
    tick(); tick();
    rst = 1'b1; id_valid = 1'b0;
    tick();

    // Streaming: five back-to-back instructions
    for (int i = 1; i <= 5; i++) begin
      rand_fields(); reg1 = 32'(i); id_valid = 1'b1; ex_ready = 1'b1;
      tick();
    end
    id_valid = 1'b0;
    tick(); tick();

    // Backpressure: A then B while EX stalls, then release
    ex_ready = 1'b0;
    rand_fields(); reg1 = 32'hA; id_valid = 1'b1; tick();
    rand_fields(); reg1 = 32'hB; tick();
    rand_fields(); reg1 = 32'hC; tick();
    tick();
    id_valid = 1'b0; ex_ready = 1'b1;
    tick(); tick(); tick();

    // Flush with skid full and a same-cycle offered instruction
    ex_ready = 1'b0; id_valid = 1'b1;
    rand_fields(); nxt = 1'b1; tick();
    rand_fields(); nxt = 1'b1; tick();
    rand_fields(); flush = 1'b1; ex_ready = 1'b1; tick();
    flush = 1'b0; id_valid = 1'b0; tick(); tick();

    // Delay slot: branch announces the slot, next instruction sits in it
    rand_fields(); nxt = 1'b1; isd = 1'b0; id_valid = 1'b1; tick();
    rand_fields(); nxt = 1'b0; isd = 1'b1; tick();
    id_valid = 1'b0; tick(); tick();

    // Idle saturation from a fresh reset
    rst = 1'b0; tick();
    rst = 1'b1; ex_ready = 1'b1; id_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("idle_sat", 0, 128'(idle[0]), 128'(4'hF));
    chk("idle_sat", 1, 128'(idle[1]), 128'(4'hF));

    // SKID=0 ready follows ex_ready combinationally while full
    rand_fields(); id_valid = 1'b1; tick();
    id_valid = 1'b0; ex_ready = 1'b0; #1;
    chk("ready_follow_lo", 0, 128'(rdy[0]), 128'(1'b0));
    ex_ready = 1'b1; #1;
    chk("ready_follow_hi", 0, 128'(rdy[0]), 128'(1'b1));
    tick();

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      rand_fields();
      id_valid = ($urandom % 4) != 0;
      ex_ready = ($urandom % 3) != 0;
      flush    = ($urandom % 16) == 0;
      rst      = ($urandom % 64) != 0;
      tick();
    end
    rst = 1'b1; flush = 1'b0; id_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
